id_stage_block: RTL and testbench
=================================

# id_stage_block

Instruction-decode stage sitting directly downstream of program-memory fetch. It consumes the fetched instruction word and fetch address, and registers decoded fields and register operands into the ID/EX pipeline register. It detects load-use and branch-operand hazards and resolves BEQ/BNE/J/JAL in ID. It drives the fetch stage's `stall`, `stall_pm`, `pc_mux_sel` and `jmp_loc` controls.

## Interface

- No parameters. Widths are fixed: instruction 32, address 16, register index 5, data 32.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low.
- `ins` in 32: instruction from fetch. It is valid one cycle after its address appeared on `current_address`.
- `current_address` in 16: fetch address being issued this cycle.
- `rs_data`, `rt_data` in 32: register-file read data for `rs_addr`/`rt_addr`, combinational.
- `rs_addr`, `rt_addr` out 5: `ins[25:21]`, `ins[20:16]`, combinational.
- `stall`, `stall_pm` out 1: fetch hold and instruction hold.
- `pc_mux_sel` out 1, `jmp_loc` out 16: redirect fetch.
- ID/EX outputs, all registered:
  - `ex_valid` 1
  - `ex_opcode` 6, `ex_funct` 6
  - `ex_rs_val`, `ex_rt_val` 32
  - `ex_imm` 32, sign-extended
  - `ex_dest` 5
  - `ex_wr_en`, `ex_mem_rd`, `ex_mem_wr` 1
  - `ex_pc` 16, address of the instruction

## Operation

- `id_pc` register: loads `current_address` every cycle unless `stall`=1, so it pairs with `ins`.
- Decode uses `op=ins[31:26]`.
  - R-type `000000`: dest=`rd`, wr_en=(rd≠0).
  - ADDI `001000`: dest=`rt`.
  - LW `100011`: dest=`rt`, mem_rd.
  - SW `101011`: mem_wr, no write.
  - BEQ `000100`, BNE `000101`: no write.
  - J `000010`.
  - JAL `000011`: dest=31; `ex_imm`={16'b0, `id_pc`+1}.
  - Any other opcode is illegal and is issued as a bubble.
- Hazard `haz`, evaluated only when the ID instruction is not squashed:
  - Load-use: `ex_valid & ex_mem_rd & ex_dest≠0`, and `ex_dest` equals a source the ID instruction reads (rs for all except J/JAL; rt for R-type, SW, BEQ, BNE).
  - Branch operand: ID is BEQ/BNE, `ex_valid & ex_wr_en`, and `ex_dest` ∈ {rs, rt}.
- On `haz`=1:
  - `stall`=`stall_pm`=1 combinationally.
  - ID/EX loads a bubble (`ex_valid`, `ex_wr_en`, `ex_mem_rd`, `ex_mem_wr` = 0).
  - `pc_mux_sel`=0.
- Redirect, only when `haz`=0 and not squashed:
  - J/JAL: `jmp_loc`=`ins[15:0]`.
  - BEQ taken on `rs_data==rt_data`; BNE taken on `≠`. Target: `jmp_loc`=`id_pc`+1+`ins[15:0]`, 16-bit modulo wrap.
  - Taken: `pc_mux_sel`=1 for that cycle.
  - Not taken: `pc_mux_sel`=0, `jmp_loc`=0.
- Squash: a taken redirect sets a `squash` flop. Next cycle, `ins` is discarded: bubble into ID/EX, no hazard, no redirect. `squash` then clears.
- Issue: when no hazard, no squash, and the opcode is legal, ID/EX loads decoded fields with `ex_valid`=1.
  - Branches and J issue with `ex_wr_en`=0.
- Priority: reset > hazard > squash > redirect/issue.

## Timing

- Reset asserted, including mid-operation: all registers clear immediately.
  - All outputs 0 except `rs_addr`/`rt_addr`, which follow `ins`.
  - `squash`=0.
  - Fetch delivers `ins`=0 during reset, which decodes as an R-type NOP with wr_en=0.
- Decode-to-EX latency: 1 cycle.
- Redirect latency: 0 cycles, combinational in the ID cycle.
- A hazard stall lasts exactly 1 cycle. The held instruction re-evaluates next cycle and issues, because a bubble now occupies ID/EX.
- Taken branch costs 1 squashed slot. A stalled branch costs 1 additional cycle.
- Simultaneous hazard and taken-branch condition: the stall wins, and the branch resolves on the following cycle.
- `stall` and `stall_pm` are always equal and are never asserted in a squash cycle.

## Configuration

- `ID_ILLEGAL_OP_EN` defined:
  - Adds output `illegal_op` (1 bit, registered, reset 0).
  - `illegal_op` is set sticky when an unsquashed, unstalled illegal opcode reaches ID, and cleared only by reset.
- `ID_ILLEGAL_OP_EN` undefined:
  - The port is absent.
  - Illegal opcodes silently become bubbles.

## Test plan

- Reset: `reset`=0 mid-stream → all ID/EX outputs, `stall` and `pc_mux_sel` go to 0 before the next edge. Release reset → the first issued instruction has `ex_pc`=0.
- Load-use: `LW $3,4($1)` at 0x0000 followed by `ADD $5,$3,$2` → one cycle with `stall`=`stall_pm`=1 and `ex_valid`=0, then ADD issues with `ex_pc`=0x0001.
- BEQ taken: `rs_data`=`rt_data`=0x5, BEQ at 0x0010 with imm=0xFFFE → `pc_mux_sel`=1, `jmp_loc`=0x000F. The next `ins` is squashed (`ex_valid`=0).
- Branch hazard: `ADDI $4,$0,1` then `BNE $4,$0,+3` at 0x0021 → 1-cycle stall, then `jmp_loc`=0x0025.
- JAL at 0x00FF, target 0x1234 → `jmp_loc`=0x1234 in the ID cycle, then `ex_dest`=31, `ex_imm`=0x00000100, `ex_wr_en`=1.
- Illegal opcode `111111` → bubble issued. With `ID_ILLEGAL_OP_EN`, `illegal_op`=1 next cycle and it stays 1 until reset.

Source files
------------

// File: rtl/id_stage_block.sv
// Instruction-decode stage: decodes the fetched word into the ID/EX register, detects hazards and
// resolves BEQ/BNE/J/JAL in ID. Optional sticky illegal-opcode flag under `ID_ILLEGAL_OP_EN.
module id_stage_block (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ins,
    input  logic [15:0] current_address,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic        stall,
    output logic        stall_pm,
    output logic        pc_mux_sel,
    output logic [15:0] jmp_loc,
    output logic        ex_valid,
    output logic [5:0]  ex_opcode,
    output logic [5:0]  ex_funct,
    output logic [31:0] ex_rs_val,
    output logic [31:0] ex_rt_val,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_dest,
    output logic        ex_wr_en,
    output logic        ex_mem_rd,
    output logic        ex_mem_wr,
    output logic [15:0] ex_pc
`ifdef ID_ILLEGAL_OP_EN
    ,
    output logic        illegal_op
`endif
);

    logic [15:0] id_pc_q;
    logic        squash_q;

    logic [5:0]  op;
    logic [4:0]  rd;
    logic        is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, legal;
    logic [4:0]  dec_dest;
    logic        dec_wr, dec_mrd, dec_mwr;
    logic [31:0] dec_imm;
    logic [15:0] pc_plus1;
    logic        reads_rs, reads_rt, load_use, br_haz, haz;
    logic        take_jump, take_br, redirect, issue;

    assign op      = ins[31:26];
    assign rs_addr = ins[25:21];
    assign rt_addr = ins[20:16];
    assign rd      = ins[15:11];

    assign is_r    = (op == 6'b000000);
    assign is_addi = (op == 6'b001000);
    assign is_lw   = (op == 6'b100011);
    assign is_sw   = (op == 6'b101011);
    assign is_beq  = (op == 6'b000100);
    assign is_bne  = (op == 6'b000101);
    assign is_j    = (op == 6'b000010);
    assign is_jal  = (op == 6'b000011);
    assign legal   = is_r | is_addi | is_lw | is_sw | is_beq | is_bne | is_j | is_jal;

    assign pc_plus1 = id_pc_q + 16'd1;

    always_comb begin
        dec_dest = 5'd0;
        dec_wr   = 1'b0;
        dec_mrd  = 1'b0;
        dec_mwr  = 1'b0;
        dec_imm  = {{16{ins[15]}}, ins[15:0]};
        if (is_r) begin
            dec_dest = rd;
            dec_wr   = (rd != 5'd0);
        end else if (is_addi) begin
            dec_dest = rt_addr;
            dec_wr   = 1'b1;
        end else if (is_lw) begin
            dec_dest = rt_addr;
            dec_wr   = 1'b1;
            dec_mrd  = 1'b1;
        end else if (is_sw) begin
            dec_mwr  = 1'b1;
        end else if (is_jal) begin
            dec_dest = 5'd31;
            dec_wr   = 1'b1;
            dec_imm  = {16'd0, pc_plus1};
        end
    end

    // A squashed slot is dead: it can neither stall nor redirect.
    assign reads_rs = ~(is_j | is_jal);
    assign reads_rt = is_r | is_sw | is_beq | is_bne;
    assign load_use = ex_valid & ex_mem_rd & (ex_dest != 5'd0) &
                      ((reads_rs & (ex_dest == rs_addr)) | (reads_rt & (ex_dest == rt_addr)));
    assign br_haz   = (is_beq | is_bne) & ex_valid & ex_wr_en &
                      ((ex_dest == rs_addr) | (ex_dest == rt_addr));
    assign haz      = ~squash_q & (load_use | br_haz);

    assign stall    = haz;
    assign stall_pm = haz;

    assign take_jump  = is_j | is_jal;
    assign take_br    = (is_beq & (rs_data == rt_data)) | (is_bne & (rs_data != rt_data));
    assign redirect   = ~haz & ~squash_q & (take_jump | take_br);
    assign pc_mux_sel = redirect;
    assign jmp_loc    = !redirect ? 16'd0 :
                        take_jump ? ins[15:0] : (pc_plus1 + ins[15:0]);

    assign issue = ~haz & ~squash_q & legal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_pc_q   <= 16'd0;
            squash_q  <= 1'b0;
            ex_valid  <= 1'b0;
            ex_opcode <= 6'd0;
            ex_funct  <= 6'd0;
            ex_rs_val <= 32'd0;
            ex_rt_val <= 32'd0;
            ex_imm    <= 32'd0;
            ex_dest   <= 5'd0;
            ex_wr_en  <= 1'b0;
            ex_mem_rd <= 1'b0;
            ex_mem_wr <= 1'b0;
            ex_pc     <= 16'd0;
        end else begin
            if (!stall) begin
                id_pc_q <= current_address;
            end
            squash_q <= redirect;
            if (issue) begin
                ex_valid  <= 1'b1;
                ex_opcode <= op;
                ex_funct  <= ins[5:0];
                ex_rs_val <= rs_data;
                ex_rt_val <= rt_data;
                ex_imm    <= dec_imm;
                ex_dest   <= dec_dest;
                ex_wr_en  <= dec_wr;
                ex_mem_rd <= dec_mrd;
                ex_mem_wr <= dec_mwr;
                ex_pc     <= id_pc_q;
            end else begin
                ex_valid  <= 1'b0;
                ex_opcode <= 6'd0;
                ex_funct  <= 6'd0;
                ex_rs_val <= 32'd0;
                ex_rt_val <= 32'd0;
                ex_imm    <= 32'd0;
                ex_dest   <= 5'd0;
                ex_wr_en  <= 1'b0;
                ex_mem_rd <= 1'b0;
                ex_mem_wr <= 1'b0;
                ex_pc     <= 16'd0;
            end
        end
    end

`ifdef ID_ILLEGAL_OP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_op <= 1'b0;
        end else if (~haz & ~squash_q & ~legal) begin
            illegal_op <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_id_stage_block.sv
// Directed bench for id_stage_block: single-instruction decode table plus hand-written
// load-use, branch, squash and reset sequences.
module tb_id_stage_block;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ins;
    logic [15:0] current_address;
    logic [31:0] rs_data, rt_data;
    logic [4:0]  rs_addr, rt_addr;
    logic        stall, stall_pm, pc_mux_sel;
    logic [15:0] jmp_loc;
    logic        ex_valid;
    logic [5:0]  ex_opcode, ex_funct;
    logic [31:0] ex_rs_val, ex_rt_val, ex_imm;
    logic [4:0]  ex_dest;
    logic        ex_wr_en, ex_mem_rd, ex_mem_wr;
    logic [15:0] ex_pc;
`ifdef ID_ILLEGAL_OP_EN
    logic        illegal_op;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage_block dut (
        .clk             (clk),
        .reset           (reset),
        .ins             (ins),
        .current_address (current_address),
        .rs_data         (rs_data),
        .rt_data         (rt_data),
        .rs_addr         (rs_addr),
        .rt_addr         (rt_addr),
        .stall           (stall),
        .stall_pm        (stall_pm),
        .pc_mux_sel      (pc_mux_sel),
        .jmp_loc         (jmp_loc),
        .ex_valid        (ex_valid),
        .ex_opcode       (ex_opcode),
        .ex_funct        (ex_funct),
        .ex_rs_val       (ex_rs_val),
        .ex_rt_val       (ex_rt_val),
        .ex_imm          (ex_imm),
        .ex_dest         (ex_dest),
        .ex_wr_en        (ex_wr_en),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_wr       (ex_mem_wr),
        .ex_pc           (ex_pc)
`ifdef ID_ILLEGAL_OP_EN
        ,
        .illegal_op      (illegal_op)
`endif
    );

    typedef struct {
        logic [31:0] ins;
        logic [15:0] pc;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [4:0]  e_rsa;
        logic [4:0]  e_rta;
        logic        e_sel;
        logic [15:0] e_jmp;
        logic        e_valid;
        logic [5:0]  e_op;
        logic [4:0]  e_dest;
        logic        e_wr;
        logic        e_mrd;
        logic        e_mwr;
        logic [31:0] e_imm;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ins = 32'd0;
        current_address = 16'd0;
        rs_data = 32'd0;
        rt_data = 32'd0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // One cycle of NOP fetch so that id_pc holds pc for the next instruction.
    task automatic preload(input logic [15:0] pc);
        current_address = pc;
        ins = 32'd0;
        tick();
    endtask

    initial begin
        //            ins           pc        rsd rtd rsa rta sel jmp        v  op     dst wr mr mw imm
        vecs[0]  = '{32'h00622820, 16'h0010, 0, 0, 3, 2, 0, 16'h0000, 1, 6'h00, 5,  1, 0, 0, 32'h00002820};
        vecs[1]  = '{32'h00620020, 16'h0010, 0, 0, 3, 2, 0, 16'h0000, 1, 6'h00, 0,  0, 0, 0, 32'h00000020};
        vecs[2]  = '{32'h2024FFFF, 16'h0010, 0, 0, 1, 4, 0, 16'h0000, 1, 6'h08, 4,  1, 0, 0, 32'hFFFFFFFF};
        vecs[3]  = '{32'h8C230004, 16'h0010, 0, 0, 1, 3, 0, 16'h0000, 1, 6'h23, 3,  1, 1, 0, 32'h00000004};
        vecs[4]  = '{32'hAC230008, 16'h0010, 0, 0, 1, 3, 0, 16'h0000, 1, 6'h2B, 0,  0, 0, 1, 32'h00000008};
        vecs[5]  = '{32'h10220003, 16'h0010, 5, 6, 1, 2, 0, 16'h0000, 1, 6'h04, 0,  0, 0, 0, 32'h00000003};
        vecs[6]  = '{32'h1022FFFE, 16'h0010, 5, 5, 1, 2, 1, 16'h000F, 1, 6'h04, 0,  0, 0, 0, 32'hFFFFFFFE};
        vecs[7]  = '{32'h14220003, 16'hFFFE, 5, 6, 1, 2, 1, 16'h0002, 1, 6'h05, 0,  0, 0, 0, 32'h00000003};
        vecs[8]  = '{32'h14220003, 16'h0030, 7, 7, 1, 2, 0, 16'h0000, 1, 6'h05, 0,  0, 0, 0, 32'h00000003};
        vecs[9]  = '{32'h08001234, 16'h0040, 0, 0, 0, 0, 1, 16'h1234, 1, 6'h02, 0,  0, 0, 0, 32'h00001234};
        vecs[10] = '{32'h0C001234, 16'h00FF, 0, 0, 0, 0, 1, 16'h1234, 1, 6'h03, 31, 1, 0, 0, 32'h00000100};
        vecs[11] = '{32'hFC000000, 16'h0050, 0, 0, 0, 0, 0, 16'h0000, 0, 6'h00, 0,  0, 0, 0, 32'h00000000};

        do_reset();
        check("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_pc_mux_sel", {31'd0, pc_mux_sel}, 32'd0);

        foreach (vecs[i]) begin
            do_reset();
            preload(vecs[i].pc);
            ins = vecs[i].ins;
            rs_data = vecs[i].rsd;
            rt_data = vecs[i].rtd;
            current_address = vecs[i].pc + 16'd1;
            #1;
            check($sformatf("v%0d_rs_addr", i), {27'd0, rs_addr}, {27'd0, vecs[i].e_rsa});
            check($sformatf("v%0d_rt_addr", i), {27'd0, rt_addr}, {27'd0, vecs[i].e_rta});
            check($sformatf("v%0d_stall", i), {30'd0, stall, stall_pm}, 32'd0);
            check($sformatf("v%0d_pc_mux_sel", i), {31'd0, pc_mux_sel}, {31'd0, vecs[i].e_sel});
            check($sformatf("v%0d_jmp_loc", i), {16'd0, jmp_loc}, {16'd0, vecs[i].e_jmp});
            tick();
            check($sformatf("v%0d_ex_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].e_valid});
            check($sformatf("v%0d_ex_ctl", i), {29'd0, ex_wr_en, ex_mem_rd, ex_mem_wr},
                  {29'd0, vecs[i].e_wr, vecs[i].e_mrd, vecs[i].e_mwr});
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d_ex_opcode", i), {26'd0, ex_opcode}, {26'd0, vecs[i].e_op});
                check($sformatf("v%0d_ex_funct", i), {26'd0, ex_funct}, {26'd0, vecs[i].ins[5:0]});
                check($sformatf("v%0d_ex_dest", i), {27'd0, ex_dest}, {27'd0, vecs[i].e_dest});
                check($sformatf("v%0d_ex_imm", i), ex_imm, vecs[i].e_imm);
                check($sformatf("v%0d_ex_pc", i), {16'd0, ex_pc}, {16'd0, vecs[i].pc});
                check($sformatf("v%0d_ex_rs_val", i), ex_rs_val, vecs[i].rsd);
                check($sformatf("v%0d_ex_rt_val", i), ex_rt_val, vecs[i].rtd);
            end
        end

        // Load-use: LW $3,4($1) at 0, ADD $5,$3,$2 at 1.
        do_reset();
        preload(16'h0000);
        check("lu_first_ex_pc", {16'd0, ex_pc}, 32'd0);
        ins = 32'h8C230004;
        current_address = 16'h0001;
        tick();
        check("lu_lw_ex_pc", {16'd0, ex_pc}, 32'd0);
        check("lu_lw_mem_rd", {31'd0, ex_mem_rd}, 32'd1);
        ins = 32'h00622820;
        current_address = 16'h0002;
        #1;
        check("lu_stall", {30'd0, stall, stall_pm}, 32'd3);
        check("lu_pc_mux_sel", {31'd0, pc_mux_sel}, 32'd0);
        tick();
        check("lu_bubble", {28'd0, ex_valid, ex_wr_en, ex_mem_rd, ex_mem_wr}, 32'd0);
        check("lu_stall_released", {30'd0, stall, stall_pm}, 32'd0);
        tick();
        check("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        check("lu_add_ex_pc", {16'd0, ex_pc}, 32'h0001);
        check("lu_add_dest", {27'd0, ex_dest}, 32'd5);

        // BEQ taken at 0x10, imm -2; the following slot is squashed.
        do_reset();
        preload(16'h0010);
        ins = 32'h1022FFFE;
        rs_data = 32'd5;
        rt_data = 32'd5;
        current_address = 16'h0011;
        #1;
        check("beq_sel", {31'd0, pc_mux_sel}, 32'd1);
        check("beq_jmp", {16'd0, jmp_loc}, 32'h000F);
        tick();
        ins = 32'h2024FFFF;
        current_address = 16'h000F;
        #1;
        check("beq_sq_sel", {31'd0, pc_mux_sel}, 32'd0);
        check("beq_sq_stall", {30'd0, stall, stall_pm}, 32'd0);
        tick();
        check("beq_sq_bubble", {31'd0, ex_valid}, 32'd0);
        ins = 32'h00622820;
        current_address = 16'h0010;
        tick();
        check("beq_after_valid", {31'd0, ex_valid}, 32'd1);
        check("beq_after_pc", {16'd0, ex_pc}, 32'h000F);

        // Branch-operand hazard: ADDI $4,$0,1 at 0x20, BNE $4,$0,+3 at 0x21.
        do_reset();
        preload(16'h0020);
        ins = 32'h20040001;
        current_address = 16'h0021;
        tick();
        ins = 32'h14800003;
        rs_data = 32'd0;
        rt_data = 32'd0;
        current_address = 16'h0022;
        #1;
        check("bh_stall", {30'd0, stall, stall_pm}, 32'd3);
        check("bh_stall_sel", {31'd0, pc_mux_sel}, 32'd0);
        tick();
        check("bh_bubble", {31'd0, ex_valid}, 32'd0);
        rs_data = 32'd1;
        #1;
        check("bh_released", {30'd0, stall, stall_pm}, 32'd0);
        check("bh_sel", {31'd0, pc_mux_sel}, 32'd1);
        check("bh_jmp", {16'd0, jmp_loc}, 32'h0025);
        tick();
        check("bh_bne_pc", {16'd0, ex_pc}, 32'h0021);

        // JAL at 0xFF; squashed BEQ $31 must neither stall nor redirect.
        do_reset();
        preload(16'h00FF);
        ins = 32'h0C001234;
        current_address = 16'h0100;
        #1;
        check("jal_jmp", {16'd0, jmp_loc}, 32'h1234);
        tick();
        check("jal_dest", {27'd0, ex_dest}, 32'd31);
        check("jal_imm", ex_imm, 32'h00000100);
        check("jal_wr_en", {31'd0, ex_wr_en}, 32'd1);
        ins = 32'h13E00001;
        current_address = 16'h1234;
        #1;
        check("jal_sq_stall", {30'd0, stall, stall_pm}, 32'd0);
        check("jal_sq_sel", {31'd0, pc_mux_sel}, 32'd0);
        tick();
        check("jal_sq_bubble", {31'd0, ex_valid}, 32'd0);

        // Reset asserted in the middle of a load-use stall.
        do_reset();
        preload(16'h0000);
        ins = 32'h8C230004;
        current_address = 16'h0001;
        tick();
        ins = 32'h00622820;
        current_address = 16'h0002;
        #2;
        reset = 1'b0;
        #1;
        check("mid_reset_stall", {30'd0, stall, stall_pm}, 32'd0);
        check("mid_reset_ex", {28'd0, ex_valid, ex_wr_en, ex_mem_rd, ex_mem_wr}, 32'd0);
        check("mid_reset_dest", {27'd0, ex_dest}, 32'd0);
        check("mid_reset_sel", {15'd0, pc_mux_sel, jmp_loc}, 32'd0);
        check("mid_reset_rs_addr", {27'd0, rs_addr}, 32'd3);
        reset = 1'b1;

`ifdef ID_ILLEGAL_OP_EN
        do_reset();
        check("ill_reset", {31'd0, illegal_op}, 32'd0);
        preload(16'h0050);
        ins = 32'hFC000000;
        current_address = 16'h0051;
        tick();
        check("ill_set", {31'd0, illegal_op}, 32'd1);
        check("ill_bubble", {31'd0, ex_valid}, 32'd0);
        ins = 32'h00622820;
        tick();
        tick();
        check("ill_sticky", {31'd0, illegal_op}, 32'd1);
        reset = 1'b0;
        #1;
        check("ill_cleared", {31'd0, illegal_op}, 32'd0);
        reset = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
